counter_prog: RTL and testbench



---
 rtl/counter_pkg.sv | 8 +
 rtl/counter_prog_if.sv | 14 +
 rtl/counter_prog_next.sv | 34 +++
 rtl/counter_prog.sv | 39 +++
 tb/tb_counter_prog.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: mode encodings shared across the counter family
package counter_pkg;
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  typedef logic [1:0] mode_t;
endpackage

// File: rtl/counter_prog_if.sv
// counter_prog_if: control/data bundle between a counter user and counter_prog
interface counter_prog_if #(parameter int WIDTH = 4);
  import counter_pkg::*;
  logic enable;
  logic ci;
  mode_t mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic rco;
  logic load;
  logic tc;
  modport master(output enable, ci, mode, D, input Q, rco, load, tc);
  modport slave(input enable, ci, mode, D, output Q, rco, load, tc);
endinterface

// File: rtl/counter_prog_next.sv
// counter_prog_next: combinational next-count, limit-hit and lookahead terminal count
module counter_prog_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             count_ok,
  input  logic             load_ok,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap,
  output logic             tc
);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);
  logic [WIDTH:0] sum;
  logic down;
  logic hit;
  always_comb begin
    down = mode == MODE_DOWN;
    sum = {1'b0, q} + (mode == MODE_STEP ? STEP_W : ONE_W);
    hit = down ? q == '0 : sum[WIDTH];
    wrap = mode != MODE_LOAD && hit;
    tc = count_ok && wrap;
    next_q = mode == MODE_LOAD ? (load_ok ? d : q)
           : !count_ok ? q
           : down ? (hit && SATURATE ? '0 : q - 1'b1)
           : (hit && SATURATE ? '1 : sum[WIDTH-1:0]);
  end
endmodule

// File: rtl/counter_prog.sv
// counter_prog: programmable up/down/step/load counter with cascade carry and saturation
module counter_prog
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP = 3,
  parameter bit SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset,
  counter_prog_if.slave bus
);
  logic [WIDTH-1:0] next_q;
  logic wrap;
  logic tc_raw;
  counter_prog_next #(.WIDTH(WIDTH), .STEP(STEP), .SATURATE(SATURATE)) u_next (
    .q(bus.Q),
    .mode(bus.mode),
    .d(bus.D),
    .count_ok(bus.enable && bus.ci),
    .load_ok(bus.enable),
    .next_q(next_q),
    .wrap(wrap),
    .tc(tc_raw)
  );
  assign bus.tc = tc_raw && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Q <= RESET_VAL;
      bus.rco <= 1'b0;
      bus.load <= 1'b0;
    end else begin
      bus.Q <= next_q;
      bus.rco <= tc_raw;
      bus.load <= bus.enable && bus.mode == MODE_LOAD;
    end
  end
endmodule

// File: tb/tb_counter_prog.sv
// tb_counter_prog: randomized scoreboard bench for wrap, saturate and chained instances
module tb_counter_prog;
  import counter_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic ci = 1'b0;
  mode_t mode = MODE_UP;
  logic [3:0] d = 4'd0;
  always #5 clk = ~clk;
  counter_prog_if #(4) ia ();
  counter_prog_if #(4) ib ();
  counter_prog_if #(4) il ();
  counter_prog_if #(4) ih ();
  assign ia.enable = en;
  assign ia.ci = ci;
  assign ia.mode = mode;
  assign ia.D = d;
  assign ib.enable = en;
  assign ib.ci = ci;
  assign ib.mode = mode;
  assign ib.D = d;
  assign il.enable = en;
  assign il.ci = ci;
  assign il.mode = mode;
  assign il.D = d;
  assign ih.enable = en;
  assign ih.ci = il.tc;
  assign ih.mode = mode;
  assign ih.D = d;
  counter_prog #(.WIDTH(4), .STEP(3), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_a (.clk(clk), .reset(reset), .bus(ia));
  counter_prog #(.WIDTH(4), .STEP(3), .SATURATE(1'b1), .RESET_VAL(4'd5)) u_b (.clk(clk), .reset(reset), .bus(ib));
  counter_prog #(.WIDTH(4), .STEP(3), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_lo (.clk(clk), .reset(reset), .bus(il));
  counter_prog #(.WIDTH(4), .STEP(3), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_hi (.clk(clk), .reset(reset), .bus(ih));
  typedef struct packed {
    logic [3:0][3:0] q;
    logic [3:0] rco;
    logic [3:0] ld;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  int mq[4] = '{0, 0, 0, 0};
  // Reference behaviour of one 4-bit stage in plain integer arithmetic.
  function automatic void mstep(input int q, input bit sat, input int rv, input bit rst, input bit e,
                                input bit c, input int md, input int dd,
                                output int nq, output bit rco, output bit ld, output bit tc);
    int inc;
    inc = md == 2 ? 3 : 1;
    tc = 1'b0;
    rco = 1'b0;
    ld = 1'b0;
    nq = q;
    if (!rst && md != 3) tc = e && c && (md == 1 ? q == 0 : q + inc > 15);
    if (rst) nq = rv;
    else if (md == 3) begin
      ld = e;
      if (e) nq = dd;
    end else if (e && c) begin
      if (md == 1) begin
        rco = q == 0;
        nq = q == 0 ? (sat ? 0 : 15) : q - 1;
      end else begin
        rco = q + inc > 15;
        nq = rco ? (sat ? 15 : q + inc - 16) : q + inc;
      end
    end
  endfunction
  task automatic cyc(input bit r, input bit e, input bit c, input mode_t m, input logic [3:0] dd);
    exp_t x;
    int nq;
    bit ro, lo, t, lo_tc;
    logic [3:0] gtc;
    @(negedge clk);
    reset = r;
    en = e;
    ci = c;
    mode = m;
    d = dd;
    #1;
    gtc = {ih.tc, il.tc, ib.tc, ia.tc};
    lo_tc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mstep(mq[i], i == 1, i == 1 ? 5 : 0, r, e, i == 3 ? lo_tc : c, int'(m), int'(dd), nq, ro, lo, t);
      if (gtc[i] !== t) begin
        errors++;
        $display("FAIL tc[%0d] at %0t: got %b want %b", i, $time, gtc[i], t);
      end
      if (i == 2) lo_tc = t;
      x.q[i] = 4'(nq);
      x.rco[i] = ro;
      x.ld[i] = lo;
      mq[i] = nq;
    end
    sb.push_back(x);
  endtask
  initial begin
    exp_t x;
    logic [3:0][3:0] gq;
    logic [3:0] gr, gl;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        gq = {ih.Q, il.Q, ib.Q, ia.Q};
        gr = {ih.rco, il.rco, ib.rco, ia.rco};
        gl = {ih.load, il.load, ib.load, ia.load};
        for (int i = 0; i < 4; i++) begin
          if (gq[i] !== x.q[i]) begin
            errors++;
            $display("FAIL q[%0d] at %0t: got %0d want %0d", i, $time, gq[i], x.q[i]);
          end
          if (gr[i] !== x.rco[i]) begin
            errors++;
            $display("FAIL rco[%0d] at %0t: got %b want %b", i, $time, gr[i], x.rco[i]);
          end
          if (gl[i] !== x.ld[i]) begin
            errors++;
            $display("FAIL load[%0d] at %0t: got %b want %b", i, $time, gl[i], x.ld[i]);
          end
        end
      end
    end
  end
  initial begin
    cyc(1, 0, 0, MODE_UP, 4'd0);
    cyc(1, 1, 1, MODE_LOAD, 4'd7);
    for (int i = 0; i < 17; i++) cyc(0, 1, 1, MODE_UP, 4'd0);
    cyc(0, 1, 1, MODE_LOAD, 4'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, MODE_DOWN, 4'd0);
    cyc(0, 1, 1, MODE_LOAD, 4'd14);
    cyc(0, 1, 1, MODE_STEP, 4'd0);
    cyc(0, 1, 1, MODE_STEP, 4'd0);
    cyc(0, 1, 0, MODE_LOAD, 4'd11);
    cyc(0, 1, 1, MODE_STEP, 4'd0);
    cyc(0, 1, 0, MODE_LOAD, 4'd9);
    cyc(0, 1, 0, MODE_UP, 4'd0);
    cyc(0, 0, 1, MODE_LOAD, 4'd3);
    cyc(0, 0, 1, MODE_UP, 4'd3);
    cyc(1, 1, 1, MODE_LOAD, 4'd5);
    cyc(0, 1, 1, MODE_LOAD, 4'd15);
    cyc(1, 1, 1, MODE_UP, 4'd0);
    cyc(0, 1, 1, MODE_UP, 4'd0);
    cyc(1, 1, 1, MODE_UP, 4'd0);
    for (int i = 0; i < 258; i++) cyc(0, 1, 1, MODE_UP, 4'd0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, MODE_DOWN, 4'd0);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0,
          mode_t'($urandom_range(0, 3)), 4'($urandom));
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
